// File: rtl/vga_ctrl_pkg.sv
// Shared types and AHB-Lite constants for the VGA character write sequencer.
package vga_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ADDR = 2'd1,
    DATA = 2'd2
  } seq_state_t;

  localparam logic [1:0]  HTRANS_IDLE   = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ = 2'b10;
  localparam logic [31:0] VGA_BASE_ADDR = 32'h5000_0000;

endpackage

// File: rtl/vga_char_fifo.sv
// Synchronous character FIFO; push is ignored when full, pop is ignored when empty.
module vga_char_fifo #(
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [7:0]               push_data,
  input  logic                     pop,
  output logic [7:0]               head,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [AW:0]   CNT_ONE  = (AW+1)'(1);
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  logic          do_push, do_pop;

  assign full    = (count_q == CNT_FULL);
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // Next pointers and occupancy; power-of-two depth lets the pointers wrap naturally.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (do_pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  // Storage array carries no reset; only the pointers define validity.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data;
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/vga_char_write_sequencer.sv
// Two-requester round-robin front end feeding a character FIFO, drained by a
// single-beat AHB-Lite write FSM to the VGA text peripheral.
//
// state | meaning
// IDLE  | bus idle; waits for a queued char (and vsync window when gated)
// ADDR  | address phase: NONSEQ write to the VGA address, held until HREADYOUT
// DATA  | data phase: FIFO head on HWDATA; completes, pops and counts on HREADYOUT
module vga_char_write_sequencer
  import vga_ctrl_pkg::*;
#(
  parameter int          FIFO_DEPTH   = 8,
  parameter logic [31:0] VGA_ADDR     = VGA_BASE_ADDR,
  parameter bit          VBLANK_ONLY  = 1'b1,
  parameter logic        VSYNC_ACTIVE = 1'b0
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic                          req0_valid,
  input  logic [7:0]                    req0_data,
  output logic                          req0_ready,
  input  logic                          req1_valid,
  input  logic [7:0]                    req1_data,
  output logic                          req1_ready,
  input  logic                          VSYNC,
  input  logic                          HREADYOUT,
  output logic [31:0]                   HADDR,
  output logic [31:0]                   HWDATA,
  output logic [1:0]                    HTRANS,
  output logic                          HWRITE,
  output logic                          HSEL,
  output logic                          HREADY,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic [15:0]                   wr_count
);

  seq_state_t  state_q, state_d;
  logic        rr_q, rr_d;
  logic        hsel_q, hsel_d;
  logic [1:0]  htrans_q, htrans_d;
  logic [31:0] haddr_q, haddr_d;
  logic [31:0] hwdata_q, hwdata_d;
  logic [15:0] wr_count_q, wr_count_d;

  logic        grant0, grant1, push, pop, start_ok;
  logic [7:0]  push_data, fifo_head;
  logic        fifo_full, fifo_empty;

  // Round-robin arbiter; the full flag is the registered one, so a same-cycle pop does not free a slot.
  always_comb begin
    grant0 = ~HRESET & ~fifo_full & req0_valid & (~req1_valid | ~rr_q);
    grant1 = ~HRESET & ~fifo_full & req1_valid & (~req0_valid |  rr_q);
    rr_d   = rr_q;
    if (grant0)      rr_d = 1'b1;
    else if (grant1) rr_d = 1'b0;
  end

  assign push       = grant0 | grant1;
  assign push_data  = grant0 ? req0_data : req1_data;
  assign req0_ready = grant0;
  assign req1_ready = grant1;
  assign start_ok   = !VBLANK_ONLY || (VSYNC == VSYNC_ACTIVE);

  vga_char_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (HCLK),
    .rst       (HRESET),
    .push      (push),
    .push_data (push_data),
    .pop       (pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  // Transfer FSM; bus outputs are derived from the next state so they are registered.
  always_comb begin
    state_d    = state_q;
    hwdata_d   = hwdata_q;
    wr_count_d = wr_count_q;
    pop        = 1'b0;
    case (state_q)
      IDLE: if (!fifo_empty && start_ok) state_d = ADDR;
      ADDR: if (HREADYOUT) begin
        state_d  = DATA;
        hwdata_d = {24'h0, fifo_head};
      end
      DATA: if (HREADYOUT) begin
        state_d    = IDLE;
        pop        = 1'b1;
        wr_count_d = wr_count_q + 16'd1;
      end
      default: state_d = IDLE;
    endcase
    hsel_d   = (state_d == ADDR);
    htrans_d = hsel_d ? HTRANS_NONSEQ : HTRANS_IDLE;
    haddr_d  = hsel_d ? VGA_ADDR : 32'h0;
  end

  // State, arbitration pointer and registered bus outputs.
  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      hsel_q     <= 1'b0;
      htrans_q   <= HTRANS_IDLE;
      haddr_q    <= 32'h0;
      hwdata_q   <= 32'h0;
      wr_count_q <= 16'h0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      hsel_q     <= hsel_d;
      htrans_q   <= htrans_d;
      haddr_q    <= haddr_d;
      hwdata_q   <= hwdata_d;
      wr_count_q <= wr_count_d;
    end
  end

  assign HSEL     = hsel_q;
  assign HWRITE   = hsel_q;
  assign HTRANS   = htrans_q;
  assign HADDR    = haddr_q;
  assign HWDATA   = hwdata_q;
  assign HREADY   = HREADYOUT;
  assign wr_count = wr_count_q;
  assign busy     = (state_q != IDLE) | ~fifo_empty;

endmodule

// File: tb/tb_vga_char_write_sequencer.sv
// Directed bench for the VGA character write sequencer.
module tb_vga_char_write_sequencer;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        req0_valid, req1_valid;
  logic [7:0]  req0_data, req1_data;
  logic        req0_ready, req1_ready;
  logic        VSYNC, HREADYOUT;
  logic [31:0] HADDR, HWDATA;
  logic [1:0]  HTRANS;
  logic        HWRITE, HSEL, HREADY, busy;
  logic [3:0]  fifo_count;
  logic [15:0] wr_count;

  int checks = 0;
  int passed = 0;

  always #5 HCLK = ~HCLK;

  vga_char_write_sequencer dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .req0_valid (req0_valid),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .VSYNC      (VSYNC),
    .HREADYOUT  (HREADYOUT),
    .HADDR      (HADDR),
    .HWDATA     (HWDATA),
    .HTRANS     (HTRANS),
    .HWRITE     (HWRITE),
    .HSEL       (HSEL),
    .HREADY     (HREADY),
    .busy       (busy),
    .fifo_count (fifo_count),
    .wr_count   (wr_count)
  );

  task automatic do_reset();
    HRESET = 1'b1;
    req0_valid = 1'b0; req0_data = 8'h0;
    req1_valid = 1'b0; req1_data = 8'h0;
    VSYNC = 1'b0; HREADYOUT = 1'b1;
    repeat (2) @(negedge HCLK);
    HRESET = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    HRESET = 1'b1;
    @(negedge HCLK); #1;
    checks++; if ({HSEL, HWRITE, HTRANS} !== 4'b0) $display("FAIL rst_ctrl: got %b expected 0000", {HSEL, HWRITE, HTRANS}); else passed++;
    checks++; if (HADDR !== 32'h0) $display("FAIL rst_haddr: got %h expected 00000000", HADDR); else passed++;
    checks++; if (HWDATA !== 32'h0) $display("FAIL rst_hwdata: got %h expected 00000000", HWDATA); else passed++;
    checks++; if ({busy, req0_ready, req1_ready} !== 3'b0) $display("FAIL rst_flags: got %b expected 000", {busy, req0_ready, req1_ready}); else passed++;
    checks++; if ({fifo_count, wr_count} !== 20'h0) $display("FAIL rst_counts: got %h expected 00000", {fifo_count, wr_count}); else passed++;
    HRESET = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    @(negedge HCLK); req0_valid = 1'b1; req0_data = 8'h41; #1;
    checks++; if (req0_ready !== 1'b1) $display("FAIL t1_ready: got %b expected 1", req0_ready); else passed++;
    @(negedge HCLK); req0_valid = 1'b0;
    checks++; if ({HSEL, fifo_count} !== 5'b0_0001) $display("FAIL t1_idle: got hsel/count %b expected 0_0001", {HSEL, fifo_count}); else passed++;
    @(negedge HCLK);
    checks++; if ({HSEL, HWRITE, HTRANS} !== 4'b1110) $display("FAIL t1_addr_ctrl: got %b expected 1110", {HSEL, HWRITE, HTRANS}); else passed++;
    checks++; if (HADDR !== 32'h5000_0000) $display("FAIL t1_haddr: got %h expected 50000000", HADDR); else passed++;
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'h41) $display("FAIL t1_hwdata: got %h expected 00000041", HWDATA); else passed++;
    checks++; if ({HSEL, HTRANS, HADDR} !== 35'h0) $display("FAIL t1_data_idle: got %h expected 0", {HSEL, HTRANS, HADDR}); else passed++;
    @(negedge HCLK);
    checks++; if (wr_count !== 16'd1) $display("FAIL t1_wr_count: got %0d expected 1", wr_count); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL t1_busy: got %b expected 0", busy); else passed++;
  endtask

  task automatic test_round_robin();
    logic [7:0] exp_chr [6] = '{8'h10, 8'h20, 8'h11, 8'h21, 8'h12, 8'h22};
    int n0 = 0, n1 = 0, acc = 0, widx = 0;
    logic prev_hsel = 1'b0;
    do_reset();
    for (int cyc = 0; cyc < 40; cyc++) begin
      @(negedge HCLK);
      if (prev_hsel && widx < 6) begin
        checks++; if (HWDATA !== {24'h0, exp_chr[widx]}) $display("FAIL t2_hwdata%0d: got %h expected %h", widx, HWDATA, exp_chr[widx]); else passed++;
        widx++;
      end
      prev_hsel  = HSEL;
      req0_valid = (n0 < 3); req0_data = 8'(8'h10 + n0);
      req1_valid = (n1 < 3); req1_data = 8'(8'h20 + n1);
      #1;
      if (acc < 6) begin
        checks++; if ({req1_ready, req0_ready} !== ((acc % 2 == 0) ? 2'b01 : 2'b10)) $display("FAIL t2_grant%0d: got %b expected %b", acc, {req1_ready, req0_ready}, (acc % 2 == 0) ? 2'b01 : 2'b10); else passed++;
      end
      if (req0_ready) n0++;
      if (req1_ready) n1++;
      if (req0_ready || req1_ready) acc++;
    end
    req0_valid = 1'b0; req1_valid = 1'b0;
    checks++; if (widx !== 6) $display("FAIL t2_writes_seen: got %0d expected 6", widx); else passed++;
    checks++; if (wr_count !== 16'd6) $display("FAIL t2_wr_count: got %0d expected 6", wr_count); else passed++;
  endtask

  task automatic test_full_stall();
    int n = 0;
    do_reset();
    HREADYOUT = 1'b0;
    for (int i = 0; i < 9; i++) begin
      @(negedge HCLK); req0_valid = 1'b1; req0_data = 8'(8'h30 + i); #1;
      checks++; if (req0_ready !== (i < 8)) $display("FAIL t3_ready%0d: got %b expected %b", i, req0_ready, (i < 8)); else passed++;
    end
    @(negedge HCLK); req0_valid = 1'b0;
    checks++; if (fifo_count !== 4'd8) $display("FAIL t3_count_full: got %0d expected 8", fifo_count); else passed++;
    checks++; if ({HSEL, HTRANS, HADDR} !== {1'b1, 2'b10, 32'h5000_0000}) $display("FAIL t3_addr: got %h expected %h", {HSEL, HTRANS, HADDR}, {1'b1, 2'b10, 32'h5000_0000}); else passed++;
    repeat (3) @(negedge HCLK);
    checks++; if ({HSEL, HTRANS, HADDR} !== {1'b1, 2'b10, 32'h5000_0000}) $display("FAIL t3_addr_held: got %h expected %h", {HSEL, HTRANS, HADDR}, {1'b1, 2'b10, 32'h5000_0000}); else passed++;
    HREADYOUT = 1'b1; req0_valid = 1'b1; req0_data = 8'h99; #1;
    checks++; if (req0_ready !== 1'b0) $display("FAIL t3_ready_full_addr: got %b expected 0", req0_ready); else passed++;
    @(negedge HCLK); #1;
    checks++; if (req0_ready !== 1'b0) $display("FAIL t3_ready_full_pop: got %b expected 0", req0_ready); else passed++;
    checks++; if (HWDATA !== 32'h30) $display("FAIL t3_hwdata: got %h expected 00000030", HWDATA); else passed++;
    @(negedge HCLK); #1;
    checks++; if ({req0_ready, fifo_count} !== 5'b1_0111) $display("FAIL t3_after_pop: got ready/count %b expected 1_0111", {req0_ready, fifo_count}); else passed++;
    req0_valid = 1'b0;
    while (busy !== 1'b0 && n < 60) begin @(negedge HCLK); n++; end
    checks++; if (busy !== 1'b0) $display("FAIL t3_drain_timeout: got busy %b expected 0", busy); else passed++;
    checks++; if (wr_count !== 16'd8) $display("FAIL t3_wr_count: got %0d expected 8", wr_count); else passed++;
  endtask

  task automatic test_vsync_gate();
    logic seen_sel = 1'b0;
    do_reset();
    VSYNC = 1'b1;
    @(negedge HCLK); req0_valid = 1'b1; req0_data = 8'h55;
    @(negedge HCLK); req0_valid = 1'b0;
    repeat (5) begin @(negedge HCLK); if (HSEL) seen_sel = 1'b1; end
    checks++; if (seen_sel !== 1'b0) $display("FAIL t4_gated: got hsel seen %b expected 0", seen_sel); else passed++;
    checks++; if (fifo_count !== 4'd1) $display("FAIL t4_count: got %0d expected 1", fifo_count); else passed++;
    VSYNC = 1'b0;
    @(negedge HCLK);
    checks++; if (HSEL !== 1'b1) $display("FAIL t4_addr: got %b expected 1", HSEL); else passed++;
    VSYNC = 1'b1;
    @(negedge HCLK);
    checks++; if (HWDATA !== 32'h55) $display("FAIL t4_hwdata: got %h expected 00000055", HWDATA); else passed++;
    HREADYOUT = 1'b0;
    @(negedge HCLK);
    checks++; if ({HWDATA, wr_count} !== {32'h55, 16'd0}) $display("FAIL t4_stall_hold: got %h expected 000000550000", {HWDATA, wr_count}); else passed++;
    HREADYOUT = 1'b1;
    @(negedge HCLK);
    checks++; if ({wr_count, fifo_count, HSEL} !== {16'd1, 4'd0, 1'b0}) $display("FAIL t4_done: got %h expected %h", {wr_count, fifo_count, HSEL}, {16'd1, 4'd0, 1'b0}); else passed++;
  endtask

  task automatic test_reset_mid_transfer();
    logic seen_sel = 1'b0;
    do_reset();
    @(negedge HCLK); req0_valid = 1'b1; req0_data = 8'h61;
    @(negedge HCLK); req0_data = 8'h62;
    @(negedge HCLK); req0_data = 8'h63;
    @(negedge HCLK); req0_valid = 1'b0;
    checks++; if ({fifo_count, HWDATA} !== {4'd3, 32'h61}) $display("FAIL t5_pre: got %h expected %h", {fifo_count, HWDATA}, {4'd3, 32'h61}); else passed++;
    HRESET = 1'b1; #1;
    checks++; if ({HSEL, HWRITE, HTRANS, HADDR, HWDATA} !== 68'h0) $display("FAIL t5_async_bus: got %h expected 0", {HSEL, HWRITE, HTRANS, HADDR, HWDATA}); else passed++;
    checks++; if ({fifo_count, busy, wr_count} !== 21'h0) $display("FAIL t5_async_state: got %h expected 0", {fifo_count, busy, wr_count}); else passed++;
    @(negedge HCLK); HRESET = 1'b0;
    repeat (6) begin @(negedge HCLK); if (HSEL) seen_sel = 1'b1; end
    checks++; if ({seen_sel, wr_count} !== 17'h0) $display("FAIL t5_no_transfer: got %h expected 0", {seen_sel, wr_count}); else passed++;
  endtask

  task automatic test_wr_count_wrap();
    int n = 0;
    do_reset();
    @(negedge HCLK);
    force dut.wr_count_q = 16'hFFFF;
    #1 release dut.wr_count_q;
    checks++; if (wr_count !== 16'hFFFF) $display("FAIL t6_preload: got %h expected ffff", wr_count); else passed++;
    @(negedge HCLK); req0_valid = 1'b1; req0_data = 8'h7E;
    @(negedge HCLK); req0_valid = 1'b0;
    while (busy !== 1'b0 && n < 20) begin @(negedge HCLK); n++; end
    checks++; if (busy !== 1'b0) $display("FAIL t6_timeout: got busy %b expected 0", busy); else passed++;
    checks++; if (wr_count !== 16'h0000) $display("FAIL t6_wrap: got %h expected 0000", wr_count); else passed++;
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_full_stall();
    test_vsync_gate();
    test_reset_mid_transfer();
    test_wr_count_wrap();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
